// File: rtl/difftest_def.sv
// Shared definitions for the difftest instruction tracker.
// Pipeline positions, metadata keys, record widths and the retired trace record.
package difftest_def;

  typedef enum logic [2:0] {
    AT_fetch     = 3'd0,
    AT_decode    = 3'd1,
    AT_rename    = 3'd2,
    AT_issue     = 3'd3,
    AT_execute   = 3'd4,
    AT_writeback = 3'd5,
    AT_commit    = 3'd6,
    AT_retire    = 3'd7
  } InstPos;

  localparam int NUMPOS = 8;

  typedef enum logic [1:0] {
    META_PC    = 2'd0,
    META_NPC   = 2'd1,
    META_INST  = 2'd2,
    META_WDATA = 2'd3
  } MetaKeys;

  localparam int NUM_META = 4;

  localparam int TS_W_DEF   = 32;
  localparam int META_W_DEF = 64;
  localparam int ID_W_MAX   = 8;

  // Fields outside their valid mask are always zero.
  typedef struct packed {
    logic [NUMPOS-1:0][TS_W_DEF-1:0]     ts;
    logic [NUMPOS-1:0]                   pos_vld;
    logic [NUM_META-1:0][META_W_DEF-1:0] meta;
    logic [NUM_META-1:0]                 meta_vld;
    logic [ID_W_MAX-1:0]                 id;
  } trace_rec_t;

endpackage

// File: rtl/difftest_inst_entry.sv
// One tracked-instruction slot: live flag, timestamps, metadata and masks.
// Ports: clk/rst, alloc/kill control, cycle stamp, update and meta channels;
// outputs live and the merged (this-cycle-writes-included) slot view.
module difftest_inst_entry
  import difftest_def::*;
#(
  parameter int SLOT    = 0,
  parameter int DEPTH   = 64,
  parameter int NUM_UPD = 4,
  parameter int NUM_POS = NUMPOS,
  parameter int NUM_MK  = NUM_META,
  parameter int META_W  = META_W_DEF,
  parameter int TS_W    = TS_W_DEF,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = $bits(InstPos),
  localparam int KW = $bits(MetaKeys)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alloc,
  input  logic                               kill,
  input  logic [TS_W-1:0]                    stamp,
  input  logic [NUM_UPD-1:0]                 upd_vld,
  input  logic [NUM_UPD-1:0][IW-1:0]         upd_id,
  input  logic [NUM_UPD-1:0][PW-1:0]         upd_pos,
  input  logic [NUM_UPD-1:0]                 meta_vld,
  input  logic [NUM_UPD-1:0][IW-1:0]         meta_id,
  input  logic [NUM_UPD-1:0][KW-1:0]         meta_key,
  input  logic [NUM_UPD-1:0][META_W-1:0]     meta_val,
  output logic                               live,
  output logic [NUM_POS-1:0][TS_W-1:0]       nxt_ts,
  output logic [NUM_POS-1:0]                 nxt_pos_vld,
  output logic [NUM_MK-1:0][META_W-1:0]      nxt_meta,
  output logic [NUM_MK-1:0]                  nxt_meta_vld
);

  localparam logic [IW-1:0] SID = IW'(SLOT);

  logic [NUM_POS-1:0][TS_W-1:0]  ts_q;
  logic [NUM_POS-1:0]            pos_q;
  logic [NUM_MK-1:0][META_W-1:0] meta_q;
  logic [NUM_MK-1:0]             mvld_q;

  // Ascending channel walk: the highest channel hitting a field wins.
  always_comb begin
    nxt_ts       = ts_q;
    nxt_pos_vld  = pos_q;
    nxt_meta     = meta_q;
    nxt_meta_vld = mvld_q;
    for (int i = 0; i < NUM_UPD; i++) begin
      if (live && upd_vld[i] && upd_id[i] == SID &&
          int'(upd_pos[i]) < NUM_POS) begin
        nxt_ts[upd_pos[i]]      = stamp;
        nxt_pos_vld[upd_pos[i]] = 1'b1;
      end
      if (live && meta_vld[i] && meta_id[i] == SID &&
          int'(meta_key[i]) < NUM_MK) begin
        nxt_meta[meta_key[i]]     = meta_val[i];
        nxt_meta_vld[meta_key[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live   <= 1'b0;
      pos_q  <= '0;
      mvld_q <= '0;
    end else if (alloc) begin
      live   <= 1'b1;
      pos_q  <= '0;
      mvld_q <= '0;
    end else begin
      if (kill) live <= 1'b0;
      pos_q  <= nxt_pos_vld;
      mvld_q <= nxt_meta_vld;
    end
  end

  // Payload needs no reset: masks gate every use of it.
  always_ff @(posedge clk) begin
    ts_q   <= nxt_ts;
    meta_q <= nxt_meta;
  end

endmodule

// File: rtl/difftest_inst_tracker.sv
// Circular tracker of in-flight instructions for difftest tracing.
// Ports: alloc (tail), upd/meta channels, retire (head), squash, out record.
module difftest_inst_tracker
  import difftest_def::*;
#(
  parameter int DEPTH   = 64,
  parameter int NUM_UPD = 4,
  parameter int NUM_POS = NUMPOS,
  parameter int NUM_MK  = NUM_META,
  parameter int META_W  = META_W_DEF,
  parameter int TS_W    = TS_W_DEF,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = $bits(InstPos),
  localparam int KW = $bits(MetaKeys)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_vld,
  output logic                           alloc_rdy,
  output logic [IW-1:0]                  alloc_id,
  input  logic [NUM_UPD-1:0]             upd_vld,
  input  logic [NUM_UPD-1:0][IW-1:0]     upd_id,
  input  logic [NUM_UPD-1:0][PW-1:0]     upd_pos,
  input  logic [NUM_UPD-1:0]             meta_vld,
  input  logic [NUM_UPD-1:0][IW-1:0]     meta_id,
  input  logic [NUM_UPD-1:0][KW-1:0]     meta_key,
  input  logic [NUM_UPD-1:0][META_W-1:0] meta_val,
  input  logic                           retire_vld,
  output logic                           retire_rdy,
  input  logic                           squash_vld,
  input  logic [IW-1:0]                  squash_id,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output trace_rec_t                     out_rec
);

  localparam int CW = IW + 1;

  logic [IW-1:0]   head_q;
  logic [IW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic [TS_W-1:0] tick_q;

  logic                          live     [DEPTH];
  logic                          kill     [DEPTH];
  logic                          alloc_at [DEPTH];
  logic [NUM_POS-1:0][TS_W-1:0]  e_ts     [DEPTH];
  logic [NUM_POS-1:0]            e_pos    [DEPTH];
  logic [NUM_MK-1:0][META_W-1:0] e_meta   [DEPTH];
  logic [NUM_MK-1:0]             e_mvld   [DEPTH];

  logic          squash_hit;
  logic          squash_head;
  logic [CW-1:0] cnt_sq;
  logic [IW-1:0] tail_sq;
  logic          retire_go;
  logic          alloc_go;
  trace_rec_t    head_rec;

  // Squash first, then retire, then alloc.
  always_comb begin
    squash_hit  = squash_vld && live[squash_id];
    squash_head = squash_hit && squash_id == head_q;
    cnt_sq      = squash_hit ? CW'(squash_id - head_q) : count_q;
    tail_sq     = squash_hit ? squash_id : tail_q;
    alloc_rdy   = count_q < CW'(DEPTH);
    retire_rdy  = count_q != '0 && (!out_vld || out_rdy);
    retire_go   = retire_vld && retire_rdy && !squash_head;
    alloc_go    = alloc_vld && alloc_rdy;
    alloc_id    = tail_sq;
  end

  // A slot at or beyond the surviving count (from head) is squashed.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      kill[s] = (squash_hit && CW'(IW'(s) - head_q) >= cnt_sq) ||
                (retire_go && IW'(s) == head_q);
      alloc_at[s] = alloc_go && IW'(s) == tail_sq;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    difftest_inst_entry #(
      .SLOT    (g),
      .DEPTH   (DEPTH),
      .NUM_UPD (NUM_UPD),
      .NUM_POS (NUM_POS),
      .NUM_MK  (NUM_MK),
      .META_W  (META_W),
      .TS_W    (TS_W)
    ) u_entry (
      .clk          (clk),
      .rst          (rst),
      .alloc        (alloc_at[g]),
      .kill         (kill[g]),
      .stamp        (tick_q),
      .upd_vld      (upd_vld),
      .upd_id       (upd_id),
      .upd_pos      (upd_pos),
      .meta_vld     (meta_vld),
      .meta_id      (meta_id),
      .meta_key     (meta_key),
      .meta_val     (meta_val),
      .live         (live[g]),
      .nxt_ts       (e_ts[g]),
      .nxt_pos_vld  (e_pos[g]),
      .nxt_meta     (e_meta[g]),
      .nxt_meta_vld (e_mvld[g])
    );
  end

  // Head view includes this cycle's writes; unset fields read as zero.
  always_comb begin
    head_rec = '0;
    for (int p = 0; p < NUM_POS; p++) begin
      if (e_pos[head_q][p]) begin
        head_rec.ts[p] = TS_W_DEF'(e_ts[head_q][p]);
      end
    end
    for (int k = 0; k < NUM_MK; k++) begin
      if (e_mvld[head_q][k]) begin
        head_rec.meta[k] = META_W_DEF'(e_meta[head_q][k]);
      end
    end
    head_rec.pos_vld  = NUMPOS'(e_pos[head_q]);
    head_rec.meta_vld = NUM_META'(e_mvld[head_q]);
    head_rec.id       = ID_W_MAX'(head_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      tick_q  <= '0;
    end else begin
      head_q  <= head_q + IW'(retire_go);
      tail_q  <= tail_sq + IW'(alloc_go);
      count_q <= cnt_sq - CW'(retire_go) + CW'(alloc_go);
      tick_q  <= tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_rec <= '0;
    end else if (retire_go) begin
      out_vld <= 1'b1;
      out_rec <= head_rec;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_difftest_inst_tracker.sv
// Bench for difftest_inst_tracker: table vectors plus corner sequences.
// Retired records are predicted by a slot model and queued as a scoreboard.
module tb_difftest_inst_tracker;
  import difftest_def::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             alloc_vld, alloc_rdy;
  logic [2:0]       alloc_id;
  logic [3:0]       upd_vld;
  logic [3:0][2:0]  upd_id;
  logic [3:0][2:0]  upd_pos;
  logic [3:0]       meta_vld;
  logic [3:0][2:0]  meta_id;
  logic [3:0][1:0]  meta_key;
  logic [3:0][63:0] meta_val;
  logic             retire_vld, retire_rdy;
  logic             squash_vld;
  logic [2:0]       squash_id;
  logic             out_vld, out_rdy;
  trace_rec_t       out_rec;

  logic             s_alloc_vld, s_alloc_rdy;
  logic [1:0]       s_alloc_id;
  logic [3:0][1:0]  s_id;
  logic             s_retire_vld, s_retire_rdy;
  logic             s_out_vld;
  trace_rec_t       s_out_rec;

  difftest_inst_tracker #(.DEPTH(D), .NUM_UPD(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_id(alloc_id),
    .upd_vld(upd_vld), .upd_id(upd_id), .upd_pos(upd_pos),
    .meta_vld(meta_vld), .meta_id(meta_id), .meta_key(meta_key),
    .meta_val(meta_val),
    .retire_vld(retire_vld), .retire_rdy(retire_rdy),
    .squash_vld(squash_vld), .squash_id(squash_id),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_rec(out_rec)
  );

  difftest_inst_tracker #(.DEPTH(4), .NUM_UPD(4)) dut_small (
    .clk(clk), .rst(rst),
    .alloc_vld(s_alloc_vld), .alloc_rdy(s_alloc_rdy),
    .alloc_id(s_alloc_id),
    .upd_vld(4'b0), .upd_id(s_id), .upd_pos(upd_pos),
    .meta_vld(4'b0), .meta_id(s_id), .meta_key(meta_key),
    .meta_val(meta_val),
    .retire_vld(s_retire_vld), .retire_rdy(s_retire_rdy),
    .squash_vld(1'b0), .squash_id(2'd0),
    .out_vld(s_out_vld), .out_rdy(1'b1), .out_rec(s_out_rec)
  );

  int total = 0;
  int bad   = 0;

  int         tb_ts;
  int         m_head, m_tail, m_cnt;
  bit         m_live [D];
  trace_rec_t m_rec  [D];
  bit         m_out_vld;
  trace_rec_t q[$];

  typedef struct {
    int          ch;
    int          pos;
    int          key;
    logic [63:0] val;
    logic [7:0]  pmask;
    logic [3:0]  mmask;
  } vec_t;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_rec(string nm, trace_rec_t act, trace_rec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_pulses();
    alloc_vld    = 1'b0;
    upd_vld      = '0;
    meta_vld     = '0;
    retire_vld   = 1'b0;
    squash_vld   = 1'b0;
    s_alloc_vld  = 1'b0;
    s_retire_vld = 1'b0;
  endtask

  task automatic model_reset();
    tb_ts = 0; m_head = 0; m_tail = 0; m_cnt = 0; m_out_vld = 0;
    for (int i = 0; i < D; i++) begin
      m_live[i] = 0;
      m_rec[i]  = '0;
    end
    q.delete();
  endtask

  // One clock: predict from the driven inputs, advance, compare outputs.
  task automatic step();
    bit rr, ar, sq_head;
    int sid, k;
    #1;
    if (!rst) begin
      rr = (m_cnt > 0) && (!m_out_vld || out_rdy);
      ar = (m_cnt < D);
      check("alloc_rdy", 64'(alloc_rdy), 64'(ar));
      check("retire_rdy", 64'(retire_rdy), 64'(rr));
      if (m_out_vld && out_rdy) begin
        void'(q.pop_front());
        m_out_vld = 0;
      end
      for (int c = 0; c < 4; c++) begin
        if (upd_vld[c] && m_live[upd_id[c]]) begin
          m_rec[upd_id[c]].ts[upd_pos[c]]      = 32'(tb_ts);
          m_rec[upd_id[c]].pos_vld[upd_pos[c]] = 1'b1;
        end
        if (meta_vld[c] && m_live[meta_id[c]]) begin
          m_rec[meta_id[c]].meta[meta_key[c]]     = meta_val[c];
          m_rec[meta_id[c]].meta_vld[meta_key[c]] = 1'b1;
        end
      end
      sq_head = 0;
      if (squash_vld && m_live[squash_id]) begin
        sid = int'(squash_id);
        k = m_cnt - ((sid - m_head + D) % D);
        for (int j = 0; j < k; j++) m_live[(sid + j) % D] = 0;
        m_cnt  -= k;
        m_tail  = sid;
        sq_head = (sid == m_head);
      end
      if (retire_vld && rr && !sq_head) begin
        q.push_back(m_rec[m_head]);
        m_live[m_head] = 0;
        m_head = (m_head + 1) % D;
        m_cnt--;
        m_out_vld = 1;
      end
      if (alloc_vld && ar) begin
        check("alloc_id", 64'(alloc_id), 64'(m_tail));
        m_rec[m_tail]    = '0;
        m_rec[m_tail].id = 8'(m_tail);
        m_live[m_tail]   = 1;
        m_tail = (m_tail + 1) % D;
        m_cnt++;
      end
      tb_ts++;
    end
    @(posedge clk);
    #1;
    if (rst) model_reset();
    check("out_vld", 64'(out_vld), 64'(m_out_vld));
    if (m_out_vld && q.size() > 0) check_rec("out_rec", out_rec, q[0]);
    clear_pulses();
  endtask

  initial begin
    vec_t       vt[4];
    trace_rec_t held;
    int         sid, ets;

    vt[0] = '{0, 0, 0, 64'h1111,                8'h01, 4'h1};
    vt[1] = '{1, 3, 1, 64'h2222,                8'h08, 4'h2};
    vt[2] = '{2, 7, 2, 64'hdead_beef,           8'h80, 4'h4};
    vt[3] = '{3, 5, 3, 64'hffff_ffff_ffff_ffff, 8'h20, 4'h8};

    model_reset();
    rst = 1'b1;
    out_rdy = 1'b1;
    upd_id = '0; upd_pos = '0;
    meta_id = '0; meta_key = '0; meta_val = '0;
    squash_id = '0; s_id = '0;
    clear_pulses();
    step();
    step();
    check("rst_alloc_rdy", 64'(alloc_rdy), 64'd1);
    check("rst_retire_rdy", 64'(retire_rdy), 64'd0);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check_rec("rst_out_rec", out_rec, '0);
    check("rst_s_alloc_rdy", 64'(s_alloc_rdy), 64'd1);
    rst = 1'b0;

    // three allocs, timestamp 5 on slot 0, retire
    for (int i = 0; i < 3; i++) begin
      alloc_vld = 1'b1;
      step();
    end
    step();
    step();
    check("ts_is_5", 64'(tb_ts), 64'd5);
    upd_vld[0] = 1'b1; upd_id[0] = 3'd0; upd_pos[0] = AT_fetch;
    step();
    retire_vld = 1'b1;
    step();
    check("fetch_ts", 64'(out_rec.ts[AT_fetch]), 64'd5);
    check("fetch_mask", 64'(out_rec.pos_vld), 64'h01);
    check("fetch_id", 64'(out_rec.id), 64'd0);
    retire_vld = 1'b1; step();
    retire_vld = 1'b1; step();
    step();

    // channels 0 and 3 race on META_NPC
    alloc_vld = 1'b1;
    sid = m_tail;
    step();
    meta_vld = 4'b1001;
    meta_id[0] = 3'(sid); meta_key[0] = META_NPC; meta_val[0] = 64'h10;
    meta_id[3] = 3'(sid); meta_key[3] = META_NPC; meta_val[3] = 64'h30;
    step();
    retire_vld = 1'b1;
    step();
    check("npc_race", out_rec.meta[META_NPC], 64'h30);
    check("npc_mask", 64'(out_rec.meta_vld), 64'h2);

    // table: write and retire in the same cycle
    for (int v = 0; v < 4; v++) begin
      alloc_vld = 1'b1;
      sid = m_tail;
      step();
      upd_vld[vt[v].ch]  = 1'b1;
      upd_id[vt[v].ch]   = 3'(sid);
      upd_pos[vt[v].ch]  = 3'(vt[v].pos);
      meta_vld[vt[v].ch] = 1'b1;
      meta_id[vt[v].ch]  = 3'(sid);
      meta_key[vt[v].ch] = 2'(vt[v].key);
      meta_val[vt[v].ch] = vt[v].val;
      retire_vld = 1'b1;
      ets = tb_ts;
      step();
      check("vec_pmask", 64'(out_rec.pos_vld), 64'(vt[v].pmask));
      check("vec_mmask", 64'(out_rec.meta_vld), 64'(vt[v].mmask));
      check("vec_ts", 64'(out_rec.ts[vt[v].pos]), 64'(ets));
      check("vec_meta", out_rec.meta[vt[v].key], vt[v].val);
      check("vec_id", 64'(out_rec.id), 64'(sid));
    end
    step();

    // output back-pressure
    alloc_vld = 1'b1; step();
    alloc_vld = 1'b1; sid = m_tail; step();
    out_rdy = 1'b0;
    retire_vld = 1'b1;
    step();
    held = out_rec;
    for (int i = 0; i < 5; i++) begin
      retire_vld = 1'b1;
      step();
      check_rec("stall_hold", out_rec, held);
      check("stall_rdy", 64'(retire_rdy), 64'd0);
    end
    out_rdy = 1'b1;
    retire_vld = 1'b1;
    step();
    check("drain_next_id", 64'(out_rec.id), 64'(sid));
    step();

    // squash with same-cycle alloc
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      alloc_vld = 1'b1;
      step();
    end
    upd_vld[1] = 1'b1; upd_id[1] = 3'd2; upd_pos[1] = AT_decode;
    step();
    squash_vld = 1'b1; squash_id = 3'd2; alloc_vld = 1'b1;
    #1;
    check("squash_alloc_id", 64'(alloc_id), 64'd2);
    step();
    for (int i = 0; i < 3; i++) begin
      retire_vld = 1'b1;
      step();
      check("squash_ret_id", 64'(out_rec.id), 64'(i));
    end
    check("squash_slot2_clean", 64'(out_rec.pos_vld), 64'd0);
    check("squash_empty", 64'(retire_rdy), 64'd0);
    step();

    // full/wrap on a 4-deep tracker
    for (int i = 0; i < 4; i++) begin
      s_alloc_vld = 1'b1;
      step();
    end
    check("small_full", 64'(s_alloc_rdy), 64'd0);
    s_alloc_vld = 1'b1;
    step();
    check("small_full_ign", 64'(s_alloc_rdy), 64'd0);
    check("small_no_out", 64'(s_out_vld), 64'd0);
    s_retire_vld = 1'b1;
    step();
    check("small_rdy_again", 64'(s_alloc_rdy), 64'd1);
    check("small_out_vld", 64'(s_out_vld), 64'd1);
    check("small_out_id", 64'(s_out_rec.id), 64'd0);
    check("small_wrap_id", 64'(s_alloc_id), 64'd0);

    // reset overrides a pending output and a busy table
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < D; i++) begin
      alloc_vld = 1'b1;
      step();
    end
    out_rdy = 1'b0;
    retire_vld = 1'b1;
    step();
    check("pre_rst_vld", 64'(out_vld), 64'd1);
    rst = 1'b1;
    retire_vld = 1'b1;
    alloc_vld = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_out_vld", 64'(out_vld), 64'd0);
    check("rst2_alloc_rdy", 64'(alloc_rdy), 64'd1);
    check("rst2_retire_rdy", 64'(retire_rdy), 64'd0);
    check_rec("rst2_out_rec", out_rec, '0);
    out_rdy = 1'b1;
    alloc_vld = 1'b1;
    step();
    upd_vld[2] = 1'b1; upd_id[2] = 3'd0; upd_pos[2] = AT_commit;
    step();
    retire_vld = 1'b1;
    step();
    check("rst2_counter", 64'(out_rec.ts[AT_commit]), 64'd1);
    step();

    check("sb_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/difftest_inst_tracker.md
DIFFTEST_INST_TRACKER -- requirements
Module: difftest_inst_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 64, tracked-instruction slots, power of two, 4..256.
REQ-002 SHALL have parameter NUM_UPD, default 4, parallel position-update channels and parallel meta-write channels.
REQ-003 SHALL have parameter NUM_POS, default NUMPOS, number of pipeline positions (InstPos).
REQ-004 SHALL have parameter NUM_MK, default NUM_META, number of metadata keys (MetaKeys).
REQ-005 SHALL have parameters META_W, default 64, metadata value width; TS_W, default 32, timestamp width.
REQ-006 SHALL have clk  input  1  clock; one clock domain, rising edge.
REQ-007 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-008 SHALL have alloc_vld input 1, alloc_rdy output 1, alloc_id output log2(DEPTH): allocate tail slot.
REQ-009 SHALL have upd_vld input NUM_UPD, upd_id input NUM_UPD x log2(DEPTH), upd_pos input NUM_UPD x InstPos: position arrival.
REQ-010 SHALL have meta_vld input NUM_UPD, meta_id input NUM_UPD x log2(DEPTH), meta_key input NUM_UPD x MetaKeys, meta_val input NUM_UPD x META_W: metadata write.
REQ-011 SHALL have retire_vld input 1, retire_rdy output 1: retire head slot.
REQ-012 SHALL have squash_vld input 1, squash_id input log2(DEPTH): drop squash_id and all younger slots.
REQ-013 SHALL have out_vld output 1, out_rdy input 1, out_rec output trace_rec_t: retired trace record (ts per position, pos-valid mask, meta per key, meta-valid mask, tracker id).

Function
REQ-014 SHALL keep a circular table with head/tail pointers and an occupancy counter 0..DEPTH; alloc_rdy = (count < DEPTH).
REQ-015 SHALL on alloc_vld&alloc_rdy present alloc_id = tail combinationally, clear that slot's pos/meta masks, mark it live, increment tail (wrap at DEPTH).
REQ-016 SHALL keep a free-running TS_W cycle counter, 0 after reset, wrapping modulo 2^TS_W.
REQ-017 SHALL on upd_vld[i] to a live slot record counter value into ts[upd_pos] and set that pos-valid bit; writes to non-live slots ignored.
REQ-018 SHALL resolve same-cycle same-slot same-field collisions (position or meta key) in favour of the highest channel index; later cycles overwrite (last write wins).
REQ-019 SHALL on meta_vld[i] to a live slot store meta_val into meta[meta_key] and set its meta-valid bit.
REQ-020 SHALL drive retire_rdy = (count > 0) & (~out_vld | out_rdy); on retire_vld&retire_rdy copy head slot (including same-cycle upd/meta writes to it) into out_rec next cycle, clear live, increment head.
REQ-021 SHALL hold out_vld/out_rec stable until out_rdy; retire latency exactly 1 cycle.
REQ-022 SHALL on squash_vld with live squash_id set tail = squash_id, clear live for squash_id..old tail-1, recompute count; non-live squash_id ignored.
REQ-023 SHALL order same-cycle events: squash, then retire, then alloc; retire suppressed if squash covers head; alloc uses post-squash tail.
REQ-024 SHALL ignore retire_vld when count = 0 and alloc_vld when full, with no state change.

Reset
REQ-025 SHALL on rst clear head, tail, count, counter, all live/mask bits, and out_vld to 0; out_rec to 0; alloc_rdy 1, retire_rdy 0.
REQ-026 SHALL let rst override all same-cycle requests, including mid-retire and pending output.

Structure
REQ-027 SHALL add TS_W default constant and trace_rec_t typedef to package difftest_def alongside InstPos and MetaKeys.
REQ-028 SHALL use one sub-module, difftest_inst_entry, holding one slot's storage and per-channel collision muxing.

Verification
REQ-029 SHALL cover: reset, alloc 3, upd id0 pos AT_fetch at ts 5, retire -> out_rec.ts[AT_fetch]=5, mask=0x01, id 0, one cycle later.
REQ-030 SHALL cover: DEPTH=4, 4 allocs -> alloc_rdy=0; fifth ignored; retire once -> alloc_rdy=1, next alloc_id=0.
REQ-031 SHALL cover: channels 0 and 3 write META_NPC to same slot same cycle, values 0x10/0x30 -> retired meta=0x30.
REQ-032 SHALL cover: allocs ids 0..5, squash_id 2 with alloc same cycle -> count 3, new alloc_id=2, old slot-2 data absent.
REQ-033 SHALL cover: out_rdy=0 for 5 cycles after retire -> out_rec stable, retire_rdy=0; out_rdy=1 -> drains, retire resumes.
REQ-034 SHALL cover: rst asserted with out_vld=1 and count=7 -> next cycle out_vld=0, count 0, counter 0.
